// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU operand controller: FSM encoding,
// ALU opcode constants and the operand byte-count helper.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
    EXEC,
    TX,
    TX_WAIT
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  function automatic int nbytes(input int data_size, input int byte_size);
    return (data_size + byte_size - 1) / byte_size;
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_serializer.sv
// Result serializer: latches the ALU result during EXEC and walks its bytes
// out through the transmitter, least significant byte first.
module uart_result_serializer
  import uart_alu_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  state_t               state,
  input  logic [DATA_SIZE-1:0] alu_result,
  input  logic                 tx_done,
  output logic [BYTE_SIZE-1:0] tx_data,
  output logic                 tx_start,
  output logic                 done,
  output logic                 last_byte
);

  localparam int NBYTES = nbytes(DATA_SIZE, BYTE_SIZE);
  localparam int RES_W  = NBYTES * BYTE_SIZE;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [RES_W-1:0] res_q;
  logic [IDX_W-1:0] idx;

  assign last_byte = (idx == IDX_W'(NBYTES - 1));
  assign tx_start  = (state == TX);

  always_comb begin
    tx_data = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (int'(idx) == k) tx_data = res_q[k*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  // done is registered so it lands the cycle after the final tx_done,
  // when the controller is already back in RX_A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == EXEC) begin
        res_q <= RES_W'(alu_result);
        idx   <= '0;
      end else if (state == TX_WAIT && tx_done) begin
        if (last_byte) done <= 1'b1;
        else           idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame assembler for the UART/ALU link: collects little-endian operands A/B
// and an opcode, runs the ALU for one cycle and sends the result back.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int DATA_SIZE      = 16,
  parameter int BYTE_SIZE      = 8,
  parameter int OPCODE_SIZE    = 6,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int TIMEOUT_LEN    = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [BYTE_SIZE-1:0]   i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_rx_err,
  output logic [DATA_SIZE-1:0]   o_a,
  output logic [DATA_SIZE-1:0]   o_b,
  output logic [OPCODE_SIZE-1:0] o_op,
  input  logic [DATA_SIZE-1:0]   i_alu_result,
  output logic [BYTE_SIZE-1:0]   o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic                   o_frame_err,
  output logic                   o_overrun
);

  localparam int NBYTES = nbytes(DATA_SIZE, BYTE_SIZE);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       rx_idx, rx_idx_n;
  logic [TIMEOUT_LEN-1:0] tmo_cnt, tmo_n;
  logic                   capture;
  logic                   timeout_n, frame_err_n, overrun_n;
  logic                   last_rx, last_byte;
  logic                   tmo_active, tmo_expire;

  function automatic logic [DATA_SIZE-1:0] put_byte(
    input logic [DATA_SIZE-1:0] cur,
    input logic [IDX_W-1:0]     idx,
    input logic [BYTE_SIZE-1:0] data
  );
    logic [DATA_SIZE-1:0] r;
    r = cur;
    for (int i = 0; i < DATA_SIZE; i++) begin
      if (i / BYTE_SIZE == int'(idx)) r[i] = data[i % BYTE_SIZE];
    end
    return r;
  endfunction

  assign last_rx    = (rx_idx == IDX_W'(NBYTES - 1));
  assign tmo_active = (state == RX_A && rx_idx != '0) || state == RX_B || state == RX_OP;
  assign tmo_expire = tmo_active && (tmo_cnt == TIMEOUT_LEN'(TIMEOUT_CYCLES - 1));
  assign o_busy     = !(state == RX_A && rx_idx == '0);

  // Priority in the receive states: framing error, then byte, then timeout.
  always_comb begin
    state_n     = state;
    rx_idx_n    = rx_idx;
    tmo_n       = '0;
    capture     = 1'b0;
    timeout_n   = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    case (state)
      RX_A, RX_B, RX_OP: begin
        if (i_rx_err) begin
          frame_err_n = 1'b1;
          state_n     = RX_A;
          rx_idx_n    = '0;
        end else if (i_rx_done) begin
          capture = 1'b1;
          if (state == RX_OP) begin
            state_n = EXEC;
          end else if (last_rx) begin
            state_n  = (state == RX_A) ? RX_B : RX_OP;
            rx_idx_n = '0;
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end else if (tmo_expire) begin
          timeout_n = 1'b1;
          state_n   = RX_A;
          rx_idx_n  = '0;
        end else if (tmo_active) begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      EXEC: begin
        overrun_n = i_rx_done;
        state_n   = TX;
      end
      TX: begin
        overrun_n = i_rx_done;
        state_n   = TX_WAIT;
      end
      TX_WAIT: begin
        overrun_n = i_rx_done;
        if (i_tx_done) state_n = last_byte ? RX_A : TX;
      end
      default: state_n = RX_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= RX_A;
      rx_idx      <= '0;
      tmo_cnt     <= '0;
      o_timeout   <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_n;
      rx_idx      <= rx_idx_n;
      tmo_cnt     <= tmo_n;
      o_timeout   <= timeout_n;
      o_frame_err <= frame_err_n;
      o_overrun   <= overrun_n;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_a  <= '0;
      o_b  <= '0;
      o_op <= '0;
    end else if (capture) begin
      case (state)
        RX_A:    o_a  <= put_byte(o_a, rx_idx, i_rx_data);
        RX_B:    o_b  <= put_byte(o_b, rx_idx, i_rx_data);
        default: o_op <= i_rx_data[OPCODE_SIZE-1:0];
      endcase
    end
  end

  uart_result_serializer #(
    .DATA_SIZE(DATA_SIZE),
    .BYTE_SIZE(BYTE_SIZE)
  ) u_serializer (
    .clk       (i_clock),
    .rst_n     (i_reset),
    .state     (state),
    .alu_result(i_alu_result),
    .tx_done   (i_tx_done),
    .tx_data   (o_tx_data),
    .tx_start  (o_tx_start),
    .done      (o_done),
    .last_byte (last_byte)
  );

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: a 16-bit instance for the main frames and
// an 8-bit instance for the single-byte-result case, sharing the rx/tx inputs.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  localparam int T = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_done = 1'b0, rx_err = 1'b0, tx_done = 1'b0;

  logic [15:0] a16, b16, res16;
  logic [5:0]  op16;
  logic [7:0]  tx_data16;
  logic        tx_start16, busy16, done16, timeout16, ferr16, ovr16;

  logic [7:0]  a8, b8, res8;
  logic [5:0]  op8;
  logic [7:0]  tx_data8;
  logic        tx_start8, busy8, done8, timeout8, ferr8, ovr8;

  logic       sel8 = 1'b0;
  logic       cur_start;
  logic [7:0] cur_data;

  int n_tests = 0, n_fail = 0;
  int n_done16 = 0, n_done8 = 0, n_to = 0, n_ferr = 0, n_ovr = 0;
  logic [7:0] exp_q[$];

  function automatic logic [15:0] alu16(input logic [15:0] a, b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> b[3:0];
      OP_SRL:  return a >> b[3:0];
      OP_NOR:  return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] alu8(input logic [7:0] a, b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> b[2:0];
      OP_SRL:  return a >> b[2:0];
      OP_NOR:  return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign res16     = alu16(a16, b16, op16);
  assign res8      = alu8(a8, b8, op8);
  assign cur_start = sel8 ? tx_start8 : tx_start16;
  assign cur_data  = sel8 ? tx_data8 : tx_data16;

  always #5 clk = ~clk;

  uart_alu_ctrl #(.DATA_SIZE(16), .BYTE_SIZE(8), .OPCODE_SIZE(6),
                  .TIMEOUT_CYCLES(T), .TIMEOUT_LEN(16)) dut16 (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_rx_err(rx_err), .o_a(a16), .o_b(b16), .o_op(op16), .i_alu_result(res16),
    .o_tx_data(tx_data16), .o_tx_start(tx_start16), .i_tx_done(tx_done),
    .o_busy(busy16), .o_done(done16), .o_timeout(timeout16),
    .o_frame_err(ferr16), .o_overrun(ovr16)
  );

  uart_alu_ctrl #(.DATA_SIZE(8), .BYTE_SIZE(8), .OPCODE_SIZE(6),
                  .TIMEOUT_CYCLES(T), .TIMEOUT_LEN(16)) dut8 (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_rx_err(rx_err), .o_a(a8), .o_b(b8), .o_op(op8), .i_alu_result(res8),
    .o_tx_data(tx_data8), .o_tx_start(tx_start8), .i_tx_done(tx_done),
    .o_busy(busy8), .o_done(done8), .o_timeout(timeout8),
    .o_frame_err(ferr8), .o_overrun(ovr8)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (done16)    n_done16++;
    if (done8)     n_done8++;
    if (timeout16) n_to++;
    if (ferr16)    n_ferr++;
    if (ovr16)     n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1; rx_err = err;
    @(posedge clk); #1;
    rx_done = 1'b0; rx_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0, 1'b0); send_byte(b1, 1'b0); send_byte(b2, 1'b0);
    send_byte(b3, 1'b0); send_byte(b4, 1'b0);
  endtask

  task automatic pulse_err();
    @(posedge clk); #1 rx_err = 1'b1;
    @(posedge clk); #1 rx_err = 1'b0;
  endtask

  // Acts as the transmitter: waits for each tx_start, scores the byte against
  // exp_q and answers with tx_done. Optionally pushes a stray rx byte in TX_WAIT.
  task automatic serve_tx(input int n, input bit inject_ovr);
    for (int k = 0; k < n; k++) begin
      int waited;
      waited = 0;
      while (!cur_start && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!cur_start) begin
        check("tx_start_wait", {31'b0, cur_start}, 32'd1);
        return;
      end
      if (exp_q.size() == 0) check("tx_extra_byte", exp_q.size(), 32'd1);
      else                   check("tx_byte", cur_data, exp_q.pop_front());
      if (inject_ovr && k == 0) begin
        @(posedge clk); #1 rx_data = 8'hEE; rx_done = 1'b1;
        @(posedge clk); #1 rx_done = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, t0, f0, o0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a", a16, 0);
    check("rst_b", b16, 0);
    check("rst_op", op16, 0);
    check("rst_tx_start", tx_start16, 0);
    check("rst_tx_data", tx_data16, 0);
    check("rst_busy", busy16, 0);
    check("rst_pulses", {done16, timeout16, ferr16, ovr16}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD 0x1234 + 0x5678 = 0x68AC, with the two-cycle latency to tx_start
    d0 = n_done16;
    exp_q.push_back(8'hAC); exp_q.push_back(8'h68);
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    @(negedge clk);
    check("lat_exec", tx_start16, 0);
    check("add_a", a16, 16'h1234);
    check("add_b", b16, 16'h5678);
    check("add_op", op16, 6'h20);
    @(negedge clk);
    check("lat_tx", tx_start16, 1);
    serve_tx(2, 1'b0);
    @(negedge clk);
    check("add_done", n_done16 - d0, 1);
    check("add_busy", busy16, 0);
    check("add_q_empty", exp_q.size(), 0);

    // SUB wrap 0x0001 - 0x0002 = 0xFFFF
    d0 = n_done16;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    send_frame(8'h01, 8'h00, 8'h02, 8'h00, 8'h22);
    serve_tx(2, 1'b0);
    @(negedge clk);
    check("sub_done", n_done16 - d0, 1);
    check("sub_busy", busy16, 0);

    // Timeout after three bytes; operands keep the partially captured bytes
    t0 = n_to;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    @(negedge clk);
    check("to_busy_mid", busy16, 1);
    repeat (T + 10) @(negedge clk);
    check("to_pulse", n_to - t0, 1);
    check("to_busy", busy16, 0);
    check("to_a", a16, 16'h2211);
    check("to_b", b16, 16'h0033);
    d0 = n_done16;
    exp_q.push_back(8'hAC); exp_q.push_back(8'h68);
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    serve_tx(2, 1'b0);
    @(negedge clk);
    check("to_next_done", n_done16 - d0, 1);

    // Framing error after two bytes, then error coinciding with a byte
    f0 = n_ferr;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    pulse_err();
    repeat (2) @(negedge clk);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_busy", busy16, 0);
    check("ferr_a", a16, 16'h0201);
    send_byte(8'h99, 1'b1);
    repeat (2) @(negedge clk);
    check("ferr_sim_pulse", n_ferr - f0, 2);
    check("ferr_sim_a", a16, 16'h0201);
    check("ferr_sim_busy", busy16, 0);
    d0 = n_done16;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h00);
    send_frame(8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h24);
    serve_tx(2, 1'b0);
    @(negedge clk);
    check("and_a", a16, 16'h0FF0);
    check("and_done", n_done16 - d0, 1);

    // Overrun: stray byte in TX_WAIT; XOR 0x1234 ^ 0x00FF = 0x12CB
    o0 = n_ovr;
    d0 = n_done16;
    exp_q.push_back(8'hCB); exp_q.push_back(8'h12);
    send_frame(8'h34, 8'h12, 8'hFF, 8'h00, 8'h26);
    serve_tx(2, 1'b1);
    @(negedge clk);
    check("ovr_pulse", n_ovr - o0, 1);
    check("ovr_done", n_done16 - d0, 1);
    check("ovr_a", a16, 16'h1234);
    check("ovr_b", b16, 16'h00FF);

    // Reset between the two result bytes of OR 0x1234 | 0x5678 = 0x567C
    d0 = n_done16;
    exp_q.push_back(8'h7C);
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h25);
    serve_tx(1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start16, 0);
    check("mid_rst_tx_data", tx_data16, 0);
    check("mid_rst_a", a16, 0);
    check("mid_rst_op", op16, 0);
    check("mid_rst_busy", busy16, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", n_done16 - d0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // SRL 0x8000 >> 4 = 0x0800, then SRA 0x8000 >>> 4 = 0xF800
    d0 = n_done16;
    exp_q.push_back(8'h00); exp_q.push_back(8'h08);
    send_frame(8'h00, 8'h80, 8'h04, 8'h00, 8'h02);
    serve_tx(2, 1'b0);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF8);
    send_frame(8'h00, 8'h80, 8'h04, 8'h00, 8'h03);
    serve_tx(2, 1'b0);
    @(negedge clk);
    check("shift_done", n_done16 - d0, 2);

    // 8-bit instance: 3-byte frame, single result byte 0x12 + 0x34 = 0x46
    do_reset();
    sel8 = 1'b1;
    d0 = n_done8;
    exp_q.push_back(8'h46);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h20, 1'b0);
    @(negedge clk);
    check("b8_a", a8, 8'h12);
    check("b8_b", b8, 8'h34);
    check("b8_op", op8, 6'h20);
    serve_tx(1, 1'b0);
    @(negedge clk);
    check("b8_done", n_done8 - d0, 1);
    check("b8_busy", busy8, 0);
    check("b8_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
